// File: rtl/i2c_host_pkg.sv
// rtl/i2c_host_pkg.sv - shared state/phase types and ACK levels for the I2C host master
package i2c_host_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        AACK,
        WRITE,
        WACK,
        READ,
        RACK,
        STOP
    } state_t;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } phase_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_scl_timer.sv
// rtl/i2c_scl_timer.sv - quarter-period ticker and Q0..Q3 phase generator (I2C_CLK_STRETCH_EN adds slave stretch hold)
module i2c_scl_timer
    import i2c_host_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic   clk,
    input  logic   n_rst,
    input  logic   run,
    input  logic   scl_in,
    output phase_t phase,
    output logic   q_first,
    output logic   q_last
);

    localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          hold;

`ifdef I2C_CLK_STRETCH_EN
    // While SCL is released for the high phase, a slave holding it low freezes the ticker.
    assign hold = (phase == Q2) && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign hold          = 1'b0;
`endif

    assign q_first = (cnt == '0);
    assign q_last  = (cnt == CNT_MAX) && !hold;

    // Quarter counter and phase; parked at Q0/count 0 whenever no transaction runs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (!run) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (!hold) begin
            if (cnt == CNT_MAX) begin
                cnt   <= '0;
                phase <= phase_t'(phase + 2'd1);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_host_master.sv
// rtl/i2c_host_master.sv - bit-level I2C master: START, address, write/read bytes, STOP (optional I2C_CLK_STRETCH_EN)
module i2c_host_master
    import i2c_host_pkg::*;
#(
    parameter int         CLK_DIV    = 8,
    parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       sda_out,
    output logic       scl_out,
    input  logic       go,
    input  logic       rw,
    input  logic [6:0] byte_count,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       nack
);

    state_t     state;
    state_t     state_nxt;
    phase_t     phase;
    logic       q_first;
    logic       q_last;
    logic       slot_end;
    logic       sample;
    logic       scl_std;
    logic       go_acc;
    logic [7:0] shreg;
    logic [2:0] bit_idx;
    logic [6:0] byte_cnt;
    logic       rw_q;
    logic       ack_bit;

    i2c_scl_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .run    (busy),
        .scl_in (scl_in),
        .phase  (phase),
        .q_first(q_first),
        .q_last (q_last)
    );

    assign slot_end = q_last && (phase == Q3);
    assign sample   = q_last && (phase == Q2);
    assign scl_std  = (phase == Q2) || (phase == Q3);
    assign go_acc   = go && (state == IDLE);

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: every transition except the go launch happens at the end of a bit slot.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (go) state_nxt = START;
            START: if (slot_end) state_nxt = ADDR;
            ADDR:  if (slot_end && bit_idx == 3'd0) state_nxt = AACK;
            AACK: begin
                if (slot_end) begin
                    if (ack_bit == NACK || byte_cnt == 7'd0) state_nxt = STOP;
                    else if (rw_q)                           state_nxt = READ;
                    else                                     state_nxt = WRITE;
                end
            end
            WRITE: if (slot_end && bit_idx == 3'd0) state_nxt = WACK;
            WACK: begin
                if (slot_end) begin
                    if (ack_bit == NACK || byte_cnt <= 7'd1) state_nxt = STOP;
                    else                                     state_nxt = WRITE;
                end
            end
            READ:  if (slot_end && bit_idx == 3'd0) state_nxt = RACK;
            RACK: begin
                if (slot_end) begin
                    if (byte_cnt <= 7'd1) state_nxt = STOP;
                    else                  state_nxt = READ;
                end
            end
            STOP:  if (slot_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus levels and strobes decoded from state and phase; SDA settles one clk into Q0 on a
    // fresh write byte while SCL is still low.
    always_comb begin
        sda_out = 1'b1;
        scl_out = 1'b1;
        done    = 1'b0;
        case (state)
            START: begin
                sda_out = (phase == Q0) || (phase == Q1);
                scl_out = (phase != Q3);
            end
            ADDR, WRITE: begin
                sda_out = shreg[7];
                scl_out = scl_std;
            end
            AACK, WACK, READ: begin
                scl_out = scl_std;
            end
            RACK: begin
                sda_out = (byte_cnt > 7'd1) ? ACK : NACK;
                scl_out = scl_std;
            end
            STOP: begin
                sda_out = (phase == Q2) || (phase == Q3);
                scl_out = (phase != Q0);
                done    = slot_end;
            end
            default: begin
                sda_out = 1'b1;
                scl_out = 1'b1;
            end
        endcase
        tx_req = (state == WRITE) && (bit_idx == 3'd7) && (phase == Q0) && q_first;
    end

    // Datapath: shift register, bit/byte counters, captured request and status registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shreg    <= '0;
            bit_idx  <= '0;
            byte_cnt <= '0;
            rw_q     <= 1'b0;
            ack_bit  <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            nack     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            if (go_acc) begin
                shreg    <= {SLAVE_ADDR, rw};
                bit_idx  <= 3'd7;
                byte_cnt <= byte_count;
                rw_q     <= rw;
                nack     <= 1'b0;
                busy     <= 1'b1;
            end else begin
                if (tx_req) begin
                    shreg <= tx_data;
                end else if (sample && state == READ) begin
                    shreg <= {shreg[6:0], sda_in};
                end else if (slot_end && (state == ADDR || state == WRITE)) begin
                    shreg <= {shreg[6:0], 1'b0};
                end

                // Bit index wraps 0 -> 7, ready for the next byte.
                if (slot_end && (state == ADDR || state == WRITE || state == READ)) begin
                    bit_idx <= bit_idx - 3'd1;
                end

                if (slot_end && (state == WACK || state == RACK) && byte_cnt != 7'd0) begin
                    byte_cnt <= byte_cnt - 7'd1;
                end

                if (sample) begin
                    ack_bit <= sda_in;
                end

                if (sample && state == READ && bit_idx == 3'd0) begin
                    rx_data  <= {shreg[6:0], sda_in};
                    rx_valid <= 1'b1;
                end

                if (slot_end && (state == AACK || state == WACK) && ack_bit == NACK) begin
                    nack <= 1'b1;
                end

                if (done) begin
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_host_master.sv
// tb/tb_i2c_host_master.sv - table-driven bench for i2c_host_master with a behavioural I2C slave
module tb_i2c_host_master;

    localparam int CLK_DIV = 8;
    localparam int SLOT    = 4 * CLK_DIV;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       sda_in;
    logic       scl_in;
    logic       sda_out;
    logic       scl_out;
    logic       go = 1'b0;
    logic       rw_i = 1'b0;
    logic [6:0] bc_i = '0;
    logic [7:0] tx_data = '0;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       nack;

    logic       slave_sda = 1'b1;
    logic       sda_bus;

    assign sda_bus = sda_out & slave_sda;
    assign sda_in  = sda_bus;
    assign scl_in  = scl_out;

    always #5 clk = ~clk;

    i2c_host_master #(
        .CLK_DIV   (CLK_DIV),
        .SLAVE_ADDR(7'h42)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .sda_in    (sda_in),
        .scl_in    (scl_in),
        .sda_out   (sda_out),
        .scl_out   (scl_out),
        .go        (go),
        .rw        (rw_i),
        .byte_count(bc_i),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .done      (done),
        .nack      (nack)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  src [0:127];
    logic        slv_nack_addr = 1'b0;
    logic [31:0] slv_word = '0;

    logic [7:0] wq[$];
    logic [7:0] rxq[$];
    logic       ackq[$];
    int txr_cnt = 0, done_cnt = 0, busy_clk = 0, start_cnt = 0, stop_cnt = 0;

    int   tx_cnt = 0;
    logic tx_pend = 1'b0;
    logic p_busy = 1'b0;
    logic p_sda = 1'b1, p_scl = 1'b1;
    logic s_active = 1'b0, s_addr = 1'b0, s_read = 1'b0, s_mw = 1'b0;
    logic s_dead = 1'b0, s_mdone = 1'b0;
    int   sbit = 0, s_rd_idx = 0;
    logic [7:0] ssh = '0;

    // Monitor plus behavioural slave, evaluated on the falling clock edge.
    always @(negedge clk) begin
        logic c_sda;
        logic c_scl;
        c_sda = sda_bus;
        c_scl = scl_out;

        if (busy && !p_busy) begin
            tx_cnt  = 0;
            tx_data = src[0];
            tx_pend = 1'b0;
        end
        if (tx_req) begin
            txr_cnt++;
            tx_cnt++;
            tx_pend = 1'b1;
        end else if (tx_pend) begin
            tx_data = src[tx_cnt % 128];
            tx_pend = 1'b0;
        end
        if (rx_valid) rxq.push_back(rx_data);
        if (done) done_cnt++;
        if (busy) busy_clk++;
        p_busy = busy;

        if (p_scl && c_scl && p_sda && !c_sda) begin
            start_cnt++;
            s_active = 1'b1; s_addr = 1'b1; s_read = 1'b0; s_dead = 1'b0;
            s_mdone = 1'b0; sbit = 0; s_rd_idx = 0; slave_sda = 1'b1;
        end else if (p_scl && c_scl && !p_sda && c_sda) begin
            stop_cnt++;
            s_active = 1'b0;
            slave_sda = 1'b1;
        end else if (s_active && !p_scl && c_scl) begin
            if (sbit < 8) begin
                ssh = {ssh[6:0], c_sda};
                sbit++;
                if (sbit == 8) begin
                    s_mw = s_addr || !s_read;
                    if (s_mw) wq.push_back(ssh);
                    if (s_addr) s_read = ssh[0];
                end
            end else begin
                if (!s_mw) begin
                    ackq.push_back(c_sda);
                    if (c_sda) s_mdone = 1'b1;
                    s_rd_idx++;
                end
                s_addr = 1'b0;
                sbit = 0;
            end
        end else if (s_active && p_scl && !c_scl) begin
            if (sbit == 8) begin
                if (s_mw) begin
                    if (s_addr && slv_nack_addr) begin
                        slave_sda = 1'b1;
                        s_dead = 1'b1;
                    end else begin
                        slave_sda = 1'b0;
                    end
                end else begin
                    slave_sda = 1'b1;
                end
            end else if (s_read && !s_dead && !s_mdone && s_rd_idx < 4) begin
                slave_sda = slv_word[31 - 8 * s_rd_idx - sbit];
            end else begin
                slave_sda = 1'b1;
            end
        end
        p_sda = c_sda;
        p_scl = c_scl;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic        rw;
        logic [6:0]  bc;
        logic        addr_nack;
        logic [31:0] rd_word;
        logic [7:0]  wb0;
        logic [7:0]  wb1;
        logic        exp_nack;
        int          exp_tx;
        int          exp_rx;
        int          exp_slots;
    } vec_t;

    // Launch one transaction, wait for done, then compare everything the slave and monitor saw.
    task automatic run_vec(input vec_t v, input string tag, input bit inj);
        int b_w, b_rx, b_a, b_tx, b_done, b_busy, b_st, b_sp, limit, errs, nw;
        logic [7:0] e;
        b_w = wq.size(); b_rx = rxq.size(); b_a = ackq.size();
        b_tx = txr_cnt; b_done = done_cnt; b_busy = busy_clk; b_st = start_cnt; b_sp = stop_cnt;
        slv_nack_addr = v.addr_nack;
        slv_word = v.rd_word;
        limit = (v.exp_slots + 4) * SLOT;
        @(negedge clk);
        rw_i = v.rw; bc_i = v.bc; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int k = 0; k < limit && done_cnt == b_done; k++) begin
            @(negedge clk);
            go = (inj && k == 200);
            if (go) begin rw_i = ~v.rw; bc_i = 7'd5; end
        end
        go = 1'b0;
        repeat (3) @(negedge clk);

        check({tag, "_done"}, done_cnt - b_done, 1);
        check({tag, "_nack"}, nack, v.exp_nack);
        check({tag, "_txreq"}, txr_cnt - b_tx, v.exp_tx);
        check({tag, "_busy_clks"}, busy_clk - b_busy, v.exp_slots * SLOT);
        check({tag, "_starts"}, start_cnt - b_st, 1);
        check({tag, "_stops"}, stop_cnt - b_sp, 1);

        nw = 1 + ((!v.rw && !v.exp_nack) ? int'(v.bc) : 0);
        check({tag, "_wbytes_n"}, wq.size() - b_w, nw);
        errs = 0;
        for (int i = 0; i < nw; i++) begin
            e = (i == 0) ? {7'h42, v.rw} : src[i - 1];
            if (b_w + i >= wq.size() || wq[b_w + i] !== e) errs++;
        end
        check({tag, "_wbytes_err"}, errs, 0);

        check({tag, "_rx_n"}, rxq.size() - b_rx, v.exp_rx);
        errs = 0;
        for (int i = 0; i < v.exp_rx; i++) begin
            e = v.rd_word[31 - 8 * i -: 8];
            if (b_rx + i >= rxq.size() || rxq[b_rx + i] !== e) errs++;
        end
        check({tag, "_rx_err"}, errs, 0);

        check({tag, "_acks_n"}, ackq.size() - b_a, v.exp_rx);
        errs = 0;
        for (int i = 0; i < v.exp_rx; i++) begin
            if (b_a + i >= ackq.size() || ackq[b_a + i] !== (i == v.exp_rx - 1)) errs++;
        end
        check({tag, "_acks_err"}, errs, 0);
    endtask

    vec_t tbl[6];
    vec_t lv;

    initial begin
        int k;
        for (int i = 0; i < 128; i++) src[i] = 8'h00;

        //        rw    bc  anack rd_word        wb0    wb1    nack  tx rx slots
        tbl[0] = '{1'b0, 7'd2, 1'b0, 32'h0,        8'hA5, 8'h3C, 1'b0, 2, 0, 29};
        tbl[1] = '{1'b1, 7'd4, 1'b0, 32'hDEADBEEF, 8'h00, 8'h00, 1'b0, 0, 4, 47};
        tbl[2] = '{1'b0, 7'd3, 1'b1, 32'h0,        8'h11, 8'h22, 1'b1, 0, 0, 11};
        tbl[3] = '{1'b0, 7'd0, 1'b0, 32'h0,        8'h00, 8'h00, 1'b0, 0, 0, 11};
        tbl[4] = '{1'b1, 7'd1, 1'b0, 32'h5A000000, 8'h00, 8'h00, 1'b0, 0, 1, 20};
        tbl[5] = '{1'b0, 7'd1, 1'b0, 32'h0,        8'h00, 8'hFF, 1'b0, 1, 0, 20};

        repeat (3) @(negedge clk);
        check("rst_sda", sda_out, 1);
        check("rst_scl", scl_out, 1);
        check("rst_txreq", tx_req, 0);
        check("rst_rxdata", rx_data, 0);
        check("rst_rxvalid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_nack", nack, 0);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            src[0] = tbl[i].wb0;
            src[1] = tbl[i].wb1;
            run_vec(tbl[i], $sformatf("v%0d", i), 1'b0);
        end

        // go pulsed mid-transaction must not disturb the running write.
        src[0] = 8'hA5; src[1] = 8'h3C;
        run_vec(tbl[0], "gobusy", 1'b1);

        // 81-byte write: command byte plus 80-byte header.
        src[0] = 8'h01;
        for (int i = 1; i <= 80; i++) src[i] = 8'(i * 7 + 3);
        lv = '{1'b0, 7'd81, 1'b0, 32'h0, 8'h01, 8'h0A, 1'b0, 81, 0, 740};
        run_vec(lv, "w81", 1'b0);

        // Reset in the middle of a write data byte.
        src[0] = 8'hA5; src[1] = 8'h3C;
        @(negedge clk);
        rw_i = 1'b0; bc_i = 7'd2; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        k = txr_cnt;
        for (int j = 0; j < 20 * SLOT && txr_cnt == k; j++) @(negedge clk);
        check("rstmid_txreq_seen", txr_cnt - k, 1);
        repeat (100) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("rstmid_sda", sda_out, 1);
        check("rstmid_scl", scl_out, 1);
        check("rstmid_busy", busy, 0);
        repeat (5) @(negedge clk);
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        run_vec(tbl[0], "after_rst", 1'b0);

        // go presented in the same cycle as done is ignored.
        slv_nack_addr = 1'b0;
        @(negedge clk);
        rw_i = 1'b0; bc_i = 7'd0; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        k = 0;
        while (!done && k < 20 * SLOT) begin
            @(negedge clk);
            k++;
        end
        check("gad_done_seen", done, 1);
        go = 1'b1;
        k = start_cnt;
        @(posedge clk);
        #1;
        go = 1'b0;
        check("gad_busy", busy, 0);
        repeat (40) @(negedge clk);
        check("gad_busy_later", busy, 0);
        check("gad_no_start", start_cnt - k, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
